// File: rtl/write_slave.sv
// Single-outstanding AXI3-style write slave backed by a DEPTH-word register-file memory,
// with a combinational debug read port.
module write_slave #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [3:0]        AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [3:0]        WID,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [3:0]        BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [5:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [3:0] id;
  logic [3:0] len;
  logic [1:0] burst;
  logic [7:0] addr;
  logic [3:0] cnt;
  logic       slverr, slverr_next;
  logic       decerr, decerr_next;
  logic       suppress;

  logic aw_hs, w_hs, b_hs;
  logic aw_bad, aw_out_of_range, at_len, beat_last;

  // Window mask for WRAP is (len+1)*4-1, which is simply {len, 2'b11}.
  function automatic logic [7:0] next_addr(input logic [7:0] a,
                                           input logic [1:0] bt,
                                           input logic [3:0] ln);
    logic [7:0] mask;
    mask = {2'b00, ln, 2'b11};
    case (bt)
      2'b01:   next_addr = a + 8'd4;
      2'b10:   next_addr = (a & ~mask) | ((a + 8'd4) & mask);
      default: next_addr = a;
    endcase
  endfunction

  function automatic logic [1:0] resp_code(input logic dec, input logic slv);
    if (dec)      resp_code = 2'b11;
    else if (slv) resp_code = 2'b10;
    else          resp_code = 2'b00;
  endfunction

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;

  assign aw_bad = (AWSIZE > 3'd2) || (AWBURST == 2'b11) ||
                  ((AWBURST == 2'b10) && !(AWLEN inside {4'd1, 4'd3, 4'd7, 4'd15}));
  assign aw_out_of_range = (AWADDR[31:8] != 24'd0);

  assign at_len    = (cnt == len);
  assign beat_last = WLAST || at_len;

  always_comb begin
    state_next  = state;
    slverr_next = slverr;
    decerr_next = decerr;
    case (state)
      IDLE: if (aw_hs) begin
        state_next  = DATA;
        slverr_next = aw_bad;
        decerr_next = aw_out_of_range;
      end
      DATA: if (w_hs) begin
        if ((WID != id) || (WLAST != at_len)) slverr_next = 1'b1;
        if (beat_last) state_next = RESP;
      end
      RESP: if (b_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state and registered handshake outputs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BID      <= 4'd0;
      BRESP    <= 2'b00;
      cnt      <= 4'd0;
      slverr   <= 1'b0;
      decerr   <= 1'b0;
      suppress <= 1'b0;
    end else begin
      state   <= state_next;
      slverr  <= slverr_next;
      decerr  <= decerr_next;
      AWREADY <= (state_next == IDLE);
      WREADY  <= (state_next == DATA);
      BVALID  <= (state_next == RESP);
      if (aw_hs) begin
        cnt      <= 4'd0;
        suppress <= aw_bad || aw_out_of_range;
      end else if (w_hs) begin
        cnt <= cnt + 4'd1;
      end
      if ((state == DATA) && (state_next == RESP)) begin
        BID   <= id;
        BRESP <= resp_code(decerr_next, slverr_next);
      end
    end
  end

  // Burst attributes and the running beat address
  always_ff @(posedge ACLK) begin
    if (aw_hs) begin
      id    <= AWID;
      len   <= AWLEN;
      burst <= AWBURST;
      addr  <= AWADDR[7:0];
    end else if (w_hs) begin
      addr <= next_addr(addr, burst, len);
    end
  end

  // Storage is deliberately left out of reset so completed beats survive it.
  always_ff @(posedge ACLK) begin
    if (w_hs && !suppress) begin
      for (int k = 0; k < 4; k++) begin
        if (WSTRB[k]) mem[addr[7:2]][8*k +: 8] <= WDATA[8*k +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: doc/write_slave.md
WRITE_SLAVE -- requirements
Module: write_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the write-data bus.
REQ-002 SHALL have parameter DEPTH, default 64, meaning the number of DATA_W-bit storage words (byte address span 4*DEPTH).
REQ-003 Ports SHALL be, one per line: name direction width meaning.
- ACLK in 1: the single clock; all state updates on its rising edge.
- ARESET in 1: asynchronous, active-high reset.
- AWID in 4: write address ID.
- AWADDR in 32: burst start byte address.
- AWLEN in 4: beats minus one.
- AWSIZE in 3: beat size code.
- AWBURST in 2: burst type (00 FIXED, 01 INCR, 10 WRAP).
- AWVALID in 1 / AWREADY out 1: write address handshake.
- WID in 4: write data ID.
- WDATA in DATA_W: beat data.
- WSTRB in 4: byte-lane enables.
- WLAST in 1: final beat marker.
- WVALID in 1 / WREADY out 1: write data handshake.
- BID out 4: response ID.
- BRESP out 2: response code (00 OKAY, 10 SLVERR, 11 DECERR).
- BVALID out 1 / BREADY in 1: write response handshake.
- rd_addr in 6: word index for the debug read port.
- rd_data out DATA_W: combinational mem[rd_addr].

Function
REQ-004 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE; AWREADY, WREADY, BVALID, BID and BRESP SHALL be registered.
REQ-005 IDLE: AWREADY=1, WREADY=0, BVALID=0. On AWVALID&&AWREADY, SHALL latch AWID, AWADDR, AWLEN, AWSIZE and AWBURST, clear the beat counter and error flags, and enter DATA. AWREADY deasserts the following cycle.
REQ-006 DATA: WREADY=1 starting the cycle after the AW handshake (1-cycle latency); AWREADY=0.
REQ-007 Each WVALID&&WREADY beat SHALL write WDATA byte lane k to mem[addr[7:2]] only where WSTRB[k]=1, unless writes are suppressed (REQ-011); the beat counter (4-bit) SHALL increment.
REQ-008 Address update per beat: FIXED holds; INCR adds 4; WRAP adds 4 within a window of (AWLEN+1)*4 bytes aligned to that size, returning to the window base past its top.
REQ-009 The burst SHALL end on the beat where WLAST=1 or the counter equals AWLEN, whichever is first. If the two disagree (WLAST early, or missing on beat AWLEN+1), SHALL flag SLVERR. FSM enters RESP the next cycle.
REQ-010 A beat with WID != latched AWID SHALL flag SLVERR; the beat still counts.
REQ-011 SHALL flag SLVERR and suppress all writes of the burst when any of these holds: AWSIZE > 2; AWBURST = 11; or WRAP with AWLEN not in {1,3,7,15}.
REQ-012 SHALL flag DECERR and suppress writes when AWADDR[31:8] != 0 (outside 4*DEPTH bytes). DECERR SHALL take precedence over SLVERR in BRESP.
REQ-013 RESP: BVALID=1, BID=latched AWID, BRESP per flags (else OKAY). These SHALL hold stable until BREADY; on BVALID&&BREADY, SHALL go to IDLE, with BVALID low and AWREADY high the next cycle.
REQ-014 No new AW SHALL be accepted before the B handshake completes (one outstanding burst). WVALID in IDLE/RESP SHALL be ignored, and no data SHALL be written.

Reset
REQ-015 ARESET=1 SHALL force IDLE asynchronously: AWREADY=0 while asserted and 1 from the first ACLK edge after release; WREADY=0; BVALID=0; BID=0; BRESP=00; counter and flags 0.
REQ-016 Reset mid-burst SHALL abandon the burst with no response. Memory contents SHALL NOT be reset; beats already written remain.

Verification
REQ-017 INCR: AWADDR=0x10, AWLEN=3, AWID=5, WDATA 0xA0..0xA3, WSTRB=F, WLAST on beat 4 -> mem[4..7]=0xA0..0xA3; BVALID one cycle after beat 4; BID=5, BRESP=00.
REQ-018 WRAP: AWADDR=0x1C, AWLEN=3, data 1,2,3,4 -> mem[7]=1, mem[4]=2, mem[5]=3, mem[6]=4; OKAY.
REQ-019 Strobe/FIXED: mem[2]=0xFFFFFFFF, AWADDR=0x08, FIXED, AWLEN=1, beats 0x11223344 WSTRB=0001 then 0x55667788 WSTRB=0100 -> mem[2]=0xFF66FF44; OKAY.
REQ-020 Errors: AWADDR=0x100 -> DECERR, no write. WLAST on beat 2 of AWLEN=3 -> SLVERR, burst ends after beat 2. WID mismatch -> SLVERR.
REQ-021 Backpressure/reset: BREADY held low 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0 throughout. ARESET pulsed during beat 2 of 4 -> outputs reset immediately, no BVALID, AWREADY=1 after release, beats 1-2 retained in mem.
